// File: rtl/dm_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: op and exception codes,
// FSM state type and lane/byte-enable helpers.
package dm_lsu_pkg;

    localparam logic [2:0] OP_W  = 3'd0;
    localparam logic [2:0] OP_BU = 3'd1;
    localparam logic [2:0] OP_B  = 3'd2;
    localparam logic [2:0] OP_HU = 3'd3;
    localparam logic [2:0] OP_H  = 3'd4;
    localparam logic [2:0] OP_D  = 3'd5;

    localparam logic [1:0] EXC_NONE   = 2'd0;
    localparam logic [1:0] EXC_ADEL   = 2'd1;
    localparam logic [1:0] EXC_ADES   = 2'd2;
    localparam logic [1:0] EXC_BUSERR = 2'd3;

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    // Byte lane within the bus word; bit 2 only exists on a 64-bit bus.
    function automatic logic [2:0] lane_of(input logic [2:0] addr_lo, input int unsigned dw);
        return (dw == 64) ? addr_lo : {1'b0, addr_lo[1:0]};
    endfunction

    function automatic logic [7:0] be_gen(input logic [2:0] op, input logic [2:0] lane);
        logic [7:0] be;
        case (op)
            OP_B, OP_BU: be = 8'h01 << lane;
            OP_H, OP_HU: be = 8'h03 << lane;
            OP_W:        be = 8'h0F << lane;
            OP_D:        be = 8'hFF;
            default:     be = 8'h00;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dm_lsu_ext.sv
// Combinational lane logic: load-data extraction/extension and store byte enables
// with lane-shifted write data.
module dm_lsu_ext
    import dm_lsu_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0]   rdata,
    input  logic [2:0]      rd_op,
    input  logic [2:0]      rd_lane,
    output logic [DW-1:0]   rd_ext,
    input  logic [DW-1:0]   wdata,
    input  logic [2:0]      wr_op,
    input  logic [2:0]      wr_lane,
    output logic [DW/8-1:0] wr_be,
    output logic [DW-1:0]   wr_data
);

    logic [DW-1:0] rd_sh;

    always_comb begin
        rd_sh = rdata >> {rd_lane, 3'b000};
        case (rd_op)
            OP_B:    rd_ext = DW'($signed(rd_sh[7:0]));
            OP_BU:   rd_ext = DW'(rd_sh[7:0]);
            OP_H:    rd_ext = DW'($signed(rd_sh[15:0]));
            OP_HU:   rd_ext = DW'(rd_sh[15:0]);
            // Sign-extends on a 64-bit bus, identity on a 32-bit one.
            OP_W:    rd_ext = DW'($signed(rd_sh[31:0]));
            default: rd_ext = rd_sh;
        endcase
    end

    assign wr_be   = (DW/8)'(be_gen(wr_op, wr_lane));
    assign wr_data = wdata << {wr_lane, 3'b000};

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit between the M stage and the data-memory bus: request/ack handshake
// with timeout, alignment checks, and a pipeline stall while an access is in flight.
module dm_lsu
    import dm_lsu_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_op,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_data,
    output logic [1:0]      rsp_exc,
    output logic            bus_req,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW/8-1:0] bus_be,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_ack,
    input  logic [DW-1:0]   bus_rdata,
    output logic            stall
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]      rsp_exc_q, rsp_exc_d;
    logic [2:0]      op_q, lane_q;
    logic            bus_we_q;
    logic [AW-1:0]   bus_addr_q;
    logic [BW-1:0]   bus_be_q;
    logic [DW-1:0]   bus_wdata_q;

    logic [2:0]      lane_in;
    logic            misalign, illegal, launch;
    logic [DW-1:0]   rd_ext, wr_data;
    logic [BW-1:0]   wr_be;

    assign lane_in = lane_of(req_addr[2:0], DW);

    always_comb begin
        case (req_op)
            OP_H, OP_HU: misalign = req_addr[0];
            OP_W:        misalign = |req_addr[1:0];
            OP_D:        misalign = |req_addr[2:0];
            default:     misalign = 1'b0;
        endcase
    end

    assign illegal = (req_op > OP_D) || ((req_op == OP_D) && (DW == 32));

    dm_lsu_ext #(.DW(DW)) u_ext (
        .rdata   (bus_rdata),
        .rd_op   (op_q),
        .rd_lane (lane_q),
        .rd_ext  (rd_ext),
        .wdata   (req_wdata),
        .wr_op   (req_op),
        .wr_lane (lane_in),
        .wr_be   (wr_be),
        .wr_data (wr_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_exc_d  = rsp_exc_q;
        launch     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (misalign || illegal) begin
                        rsp_exc_d  = req_we ? EXC_ADES : EXC_ADEL;
                        rsp_data_d = '0;
                        state_d    = StResp;
                    end else begin
                        launch  = 1'b1;
                        cnt_d   = '0;
                        state_d = StBus;
                    end
                end
            end
            StBus: begin
                if (bus_ack) begin
                    rsp_data_d = bus_we_q ? '0 : rd_ext;
                    rsp_exc_d  = EXC_NONE;
                    state_d    = StResp;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    rsp_exc_d  = EXC_BUSERR;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_exc_q  <= EXC_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_exc_q  <= rsp_exc_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q        <= OP_W;
            lane_q      <= '0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
        end else if (launch) begin
            op_q        <= req_op;
            lane_q      <= lane_in;
            bus_we_q    <= req_we;
            bus_addr_q  <= req_addr & ~AW'(BW - 1);
            bus_be_q    <= wr_be;
            bus_wdata_q <= wr_data;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign bus_req   = (state_q == StBus);
    assign rsp_data  = rsp_data_q;
    assign rsp_exc   = rsp_exc_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign stall     = (req_valid & ~req_ready) | (state_q != StIdle);

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu: a 32-bit and a 64-bit instance, both with TIMEOUT=4.
module tb_dm_lsu;
    import dm_lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 32-bit instance
    logic        a_valid, a_ready, a_we, a_rsp_valid, a_bus_req, a_bus_we, a_ack, a_stall;
    logic [2:0]  a_op;
    logic [31:0] a_addr, a_wdata, a_rsp_data, a_bus_addr, a_bus_wdata, a_rdata;
    logic [1:0]  a_exc;
    logic [3:0]  a_be;

    // 64-bit instance
    logic        b_valid, b_ready, b_we, b_rsp_valid, b_bus_req, b_bus_we, b_ack, b_stall;
    logic [2:0]  b_op;
    logic [31:0] b_addr, b_bus_addr;
    logic [63:0] b_wdata, b_rsp_data, b_bus_wdata, b_rdata;
    logic [1:0]  b_exc;
    logic [7:0]  b_be;

    dm_lsu #(.DW(32), .AW(32), .TIMEOUT(4)) u_dut32 (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we), .req_op(a_op),
        .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_exc(a_exc),
        .bus_req(a_bus_req), .bus_we(a_bus_we), .bus_addr(a_bus_addr), .bus_be(a_be),
        .bus_wdata(a_bus_wdata), .bus_ack(a_ack), .bus_rdata(a_rdata), .stall(a_stall)
    );

    dm_lsu #(.DW(64), .AW(32), .TIMEOUT(4)) u_dut64 (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we), .req_op(b_op),
        .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_exc(b_exc),
        .bus_req(b_bus_req), .bus_we(b_bus_we), .bus_addr(b_bus_addr), .bus_be(b_be),
        .bus_wdata(b_bus_wdata), .bus_ack(b_ack), .bus_rdata(b_rdata), .stall(b_stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns #1 after the accept edge.
    task automatic req32(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd);
        a_valid = 1'b1; a_we = we; a_op = op; a_addr = addr; a_wdata = wd;
        step();
        a_valid = 1'b0;
    endtask

    task automatic ack32(input logic [31:0] rd);
        a_ack = 1'b1; a_rdata = rd;
        step();
        a_ack = 1'b0;
    endtask

    task automatic req64(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [63:0] wd);
        b_valid = 1'b1; b_we = we; b_op = op; b_addr = addr; b_wdata = wd;
        step();
        b_valid = 1'b0;
    endtask

    task automatic ack64(input logic [63:0] rd);
        b_ack = 1'b1; b_rdata = rd;
        step();
        b_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cycles;
        a_valid = 0; a_we = 0; a_op = 0; a_addr = 0; a_wdata = 0; a_ack = 0; a_rdata = 0;
        b_valid = 0; b_we = 0; b_op = 0; b_addr = 0; b_wdata = 0; b_ack = 0; b_rdata = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", a_ready, 1);
        check("rst_bus_req", a_bus_req, 0);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_stall", a_stall, 0);
        check("rst_bus_be", a_be, 0);
        reset = 1'b0;
        step();

        // Signed byte load from lane 3
        req32(0, OP_B, 32'h1003, 0);
        check("ldb_bus_req", a_bus_req, 1);
        check("ldb_bus_addr", a_bus_addr, 32'h1000);
        check("ldb_bus_be", a_be, 4'b1000);
        check("ldb_bus_we", a_bus_we, 0);
        check("ldb_stall", a_stall, 1);
        check("ldb_no_rsp_yet", a_rsp_valid, 0);
        ack32(32'h80FF_1234);
        check("ldb_rsp_valid", a_rsp_valid, 1);
        check("ldb_rsp_data", a_rsp_data, 32'hFFFF_FF80);
        check("ldb_rsp_exc", a_exc, EXC_NONE);
        check("ldb_bus_req_drop", a_bus_req, 0);
        step();
        check("ldb_rsp_pulse", a_rsp_valid, 0);
        check("ldb_ready", a_ready, 1);

        req32(0, OP_BU, 32'h1002, 0);
        ack32(32'h80FF_1234);
        check("ldbu_rsp_data", a_rsp_data, 32'h0000_00FF);
        step();

        req32(0, OP_H, 32'h1002, 0);
        check("ldh_bus_be", a_be, 4'b1100);
        ack32(32'h80FF_1234);
        check("ldh_rsp_data", a_rsp_data, 32'hFFFF_80FF);
        step();

        // Halfword store into upper lanes
        req32(1, OP_H, 32'h2002, 32'h0000_ABCD);
        check("sth_bus_be", a_be, 4'b1100);
        check("sth_bus_wdata", a_bus_wdata, 32'hABCD_0000);
        check("sth_bus_addr", a_bus_addr, 32'h2000);
        check("sth_bus_we", a_bus_we, 1);
        ack32(32'hDEAD_BEEF);
        check("sth_rsp_valid", a_rsp_valid, 1);
        check("sth_rsp_exc", a_exc, EXC_NONE);
        check("sth_rsp_data", a_rsp_data, 0);
        step();

        // Misaligned word: immediate response, no bus activity
        req32(0, OP_W, 32'h3001, 0);
        check("ldw_mis_rsp_valid", a_rsp_valid, 1);
        check("ldw_mis_exc", a_exc, EXC_ADEL);
        check("ldw_mis_bus_req", a_bus_req, 0);
        step();
        check("ldw_mis_bus_req2", a_bus_req, 0);
        req32(1, OP_W, 32'h3001, 0);
        check("stw_mis_exc", a_exc, EXC_ADES);
        check("stw_mis_bus_req", a_bus_req, 0);
        step();

        req32(0, OP_D, 32'h3000, 0);
        check("ldd_dw32_exc", a_exc, EXC_ADEL);
        check("ldd_dw32_valid", a_rsp_valid, 1);
        step();
        req32(1, 3'd7, 32'h3000, 0);
        check("op7_st_exc", a_exc, EXC_ADES);
        step();

        // Ack while idle must not produce a response
        a_ack = 1'b1;
        step();
        a_ack = 1'b0;
        check("idle_ack_ignored", a_rsp_valid, 0);
        check("idle_ack_ready", a_ready, 1);

        // Timeout: bus_req for exactly TIMEOUT cycles, then bus error
        req32(0, OP_W, 32'h4000, 0);
        cycles = 0;
        while (a_bus_req && cycles < 20) begin
            cycles++;
            step();
        end
        check("tmo_bus_req_cycles", cycles, 4);
        check("tmo_rsp_valid", a_rsp_valid, 1);
        check("tmo_rsp_exc", a_exc, EXC_BUSERR);
        check("tmo_rsp_data", a_rsp_data, 0);
        check("tmo_bus_req", a_bus_req, 0);
        step();

        // Reset in the middle of a bus access
        req32(0, OP_W, 32'h5000, 0);
        check("rstmid_bus_req_before", a_bus_req, 1);
        reset = 1'b1;
        #1;
        check("rstmid_bus_req_async", a_bus_req, 0);
        step();
        check("rstmid_rsp_valid", a_rsp_valid, 0);
        reset = 1'b0;
        a_ack = 1'b1; a_rdata = 32'h1234_5678;
        step();
        a_ack = 1'b0;
        check("rstmid_no_rsp", a_rsp_valid, 0);
        check("rstmid_ready", a_ready, 1);

        // 64-bit instance
        req64(0, OP_HU, 32'h6, 0);
        check("d64_ldhu_be", b_be, 8'hC0);
        check("d64_ldhu_addr", b_bus_addr, 32'h0);
        ack64(64'hBEEF_0000_0000_0000);
        check("d64_ldhu_data", b_rsp_data, 64'h0000_0000_0000_BEEF);
        check("d64_ldhu_exc", b_exc, EXC_NONE);
        step();

        req64(0, OP_W, 32'h4, 0);
        check("d64_ldw_hi_be", b_be, 8'hF0);
        ack64(64'h8000_0000_1234_5678);
        check("d64_ldw_hi_data", b_rsp_data, 64'hFFFF_FFFF_8000_0000);
        step();

        req64(0, OP_W, 32'h0, 0);
        ack64(64'h8000_0000_1234_5678);
        check("d64_ldw_lo_data", b_rsp_data, 64'h0000_0000_1234_5678);
        step();

        req64(1, OP_B, 32'h5, 64'h0000_0000_0000_00A5);
        check("d64_stb_be", b_be, 8'h20);
        check("d64_stb_wdata", b_bus_wdata, 64'h0000_A500_0000_0000);
        ack64(64'h0);
        check("d64_stb_data", b_rsp_data, 0);
        step();

        req64(0, OP_D, 32'h4, 0);
        check("d64_ldd_mis_exc", b_exc, EXC_ADEL);
        check("d64_ldd_mis_bus", b_bus_req, 0);
        step();

        req64(0, OP_D, 32'h8, 0);
        check("d64_ldd_be", b_be, 8'hFF);
        check("d64_ldd_addr", b_bus_addr, 32'h8);
        ack64(64'h0123_4567_89AB_CDEF);
        check("d64_ldd_data", b_rsp_data, 64'h0123_4567_89AB_CDEF);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
